// File: rtl/seg_display_scan.sv
// Six-digit multiplexed common-anode 7-segment scanner with per-frame snapshot and blanking.
// Optional COLON_BLINK_EN lights dp on the m1/h1 slots when the seconds count is even.
module seg_display_scan #(
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned BLANK_CYC = 1_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_blank_lz,
    input  logic [3:0] i_s1,
    input  logic [3:0] i_s2,
    input  logic [3:0] i_m1,
    input  logic [3:0] i_m2,
    input  logic [3:0] i_h1,
    input  logic [3:0] i_h2,
    output logic [5:0] o_an,
    output logic [6:0] o_seg,
    output logic       o_dp
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [5:0][3:0]  r_snap;
    logic [5:0]       r_an;
    logic [6:0]       r_seg;
    logic             w_tick;
    logic             w_wrap;
    logic             w_active;
    logic             w_lz_hide;
    logic [3:0]       w_digit;
    logic [5:0]       w_an;
    logic [6:0]       w_seg;

    always_comb begin
        w_tick    = i_en && (r_cnt == CNT_LAST);
        w_wrap    = w_tick && (r_idx == 3'd5);
        w_cnt_nxt = r_cnt;
        w_idx_nxt = r_idx;
        if (i_en) begin
            w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
        end
        if (w_tick) begin
            w_idx_nxt = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end
    end

    always_comb begin
        w_digit = r_snap[0];
        unique case (r_idx)
            3'd0:    w_digit = r_snap[0];
            3'd1:    w_digit = r_snap[1];
            3'd2:    w_digit = r_snap[2];
            3'd3:    w_digit = r_snap[3];
            3'd4:    w_digit = r_snap[4];
            3'd5:    w_digit = r_snap[5];
            default: w_digit = r_snap[0];
        endcase
    end

    always_comb begin
        w_seg = 7'h3F;
        case (w_digit)
            4'd0:    w_seg = 7'h40;
            4'd1:    w_seg = 7'h79;
            4'd2:    w_seg = 7'h24;
            4'd3:    w_seg = 7'h30;
            4'd4:    w_seg = 7'h19;
            4'd5:    w_seg = 7'h12;
            4'd6:    w_seg = 7'h02;
            4'd7:    w_seg = 7'h78;
            4'd8:    w_seg = 7'h00;
            4'd9:    w_seg = 7'h10;
            default: w_seg = 7'h3F;  // non-BCD shows a dash
        endcase
        if (!i_en) begin
            w_seg = 7'h7F;
        end
    end

    always_comb begin
        w_active  = (r_cnt >= CNT_BLANK);
        w_lz_hide = i_blank_lz && (r_idx == 3'd5) && (r_snap[5] == 4'd0);
        w_an      = 6'h3F;
        if (i_en && w_active && !w_lz_hide) begin
            w_an = ~(6'b000001 << r_idx);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_idx  <= 3'd0;
            r_snap <= '0;
            r_an   <= 6'h3F;
            r_seg  <= 7'h7F;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_idx <= w_idx_nxt;
            r_an  <= w_an;
            r_seg <= w_seg;
            // Whole-frame snapshot keeps a mid-frame carry from tearing the display
            if (w_wrap) begin
                r_snap <= {i_h2, i_h1, i_m2, i_m1, i_s2, i_s1};
            end
        end
    end

    assign o_an  = r_an;
    assign o_seg = r_seg;

`ifdef COLON_BLINK_EN
    logic r_dp;
    logic w_dp;

    always_comb begin
        w_dp = 1'b1;
        if (i_en && w_active && ((r_idx == 3'd2) || (r_idx == 3'd4)) && !r_snap[0][0]) begin
            w_dp = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dp <= 1'b1;
        end else begin
            r_dp <= w_dp;
        end
    end

    assign o_dp = r_dp;
`else
    assign o_dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with SCAN_DIV=8, BLANK_CYC=2.
// dp expectations follow whether COLON_BLINK_EN is defined for the build.
module tb_seg_display_scan;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       blank_lz;
    logic [3:0] s1, s2, m1, m2, h1, h2;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_pass  = 0;
    int n_total = 0;
    int ecount  = 0;

`ifdef COLON_BLINK_EN
    localparam bit COLON = 1'b1;
`else
    localparam bit COLON = 1'b0;
`endif

    seg_display_scan #(
        .SCAN_DIV (8),
        .BLANK_CYC(2)
    ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_blank_lz(blank_lz),
        .i_s1      (s1),
        .i_s2      (s2),
        .i_m1      (m1),
        .i_m2      (m2),
        .i_h1      (h1),
        .i_h2      (h2),
        .o_an      (an),
        .o_seg     (seg),
        .o_dp      (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected dp: lit only when the colon feature exists and the slot calls for it
    function automatic logic dp_exp(input logic lit);
        return ~(lit & COLON);
    endfunction

    // Advance to just after posedge number k (sampled on the following negedge)
    task automatic to_edge(input int k);
        while (ecount < k) begin
            @(negedge clk);
            ecount++;
        end
    endtask

    task automatic chk(input string tag, input logic [5:0] an_e, input logic [6:0] seg_e,
                       input logic dp_e);
        n_total++;
        assert (an === an_e) n_pass++;
        else $error("FAIL %s an: got %b want %b", tag, an, an_e);
        n_total++;
        assert (seg === seg_e) n_pass++;
        else $error("FAIL %s seg: got %h want %h", tag, seg, seg_e);
        n_total++;
        assert (dp === dp_e) n_pass++;
        else $error("FAIL %s dp: got %b want %b", tag, dp, dp_e);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        blank_lz = 1'b0;
        h2 = 4'd1; h1 = 4'd2; m2 = 4'd3; m1 = 4'd4; s2 = 4'd6; s1 = 4'd5;
        repeat (3) @(negedge clk);
        chk("reset", 6'h3F, 7'h7F, 1'b1);

        @(negedge clk);
        rst_n  = 1'b1;
        ecount = 0;

        // Frame 1: snapshot is all zero
        to_edge(1);  chk("f1_s0_blank",  6'h3F, 7'h40, 1'b1);
        to_edge(3);  chk("f1_s0_active", 6'h3E, 7'h40, 1'b1);
        to_edge(19); chk("f1_s2_active", 6'h3B, 7'h40, dp_exp(1'b1));
        to_edge(43); chk("f1_s5_zero",   6'h1F, 7'h40, 1'b1);

        // Frame 2: snapshot 1 2 3 4 6 5 loaded at the first wrap
        to_edge(49); chk("f2_s0_c0", 6'h3F, 7'h12, 1'b1);
        to_edge(50); chk("f2_s0_c1", 6'h3F, 7'h12, 1'b1);
        to_edge(51); chk("f2_s0_c2", 6'h3E, 7'h12, 1'b1);
        to_edge(56); chk("f2_s0_c7", 6'h3E, 7'h12, 1'b1);
        to_edge(66);
        s1 = 4'd6;  // mid-frame change must not show until the next wrap
        to_edge(67); chk("f2_s2_m1", 6'h3B, 7'h19, 1'b1);
        to_edge(83); chk("f2_s4_h1", 6'h2F, 7'h24, 1'b1);
        to_edge(91); chk("f2_s5_h2", 6'h1F, 7'h79, 1'b1);

        // Frame 3: s1=6 captured, even seconds
        to_edge(99);  chk("f3_s0_s1",    6'h3E, 7'h02, 1'b1);
        to_edge(113); chk("f3_s2_blank", 6'h3F, 7'h19, 1'b1);
        to_edge(115); chk("f3_s2_act",   6'h3B, 7'h19, dp_exp(1'b1));
        to_edge(123); chk("f3_s3_m2",    6'h37, 7'h30, 1'b1);
        to_edge(125);
        h2 = 4'd0; m1 = 4'hC; s1 = 4'd4; blank_lz = 1'b1;

        // Frame 4: dash on m1, leading zero suppressed
        to_edge(155); chk("f4_s1_s2",   6'h3D, 7'h02, 1'b1);
        to_edge(163); chk("f4_s2_dash", 6'h3B, 7'h3F, dp_exp(1'b1));
        to_edge(179); chk("f4_s4_h1",   6'h2F, 7'h24, dp_exp(1'b1));
        to_edge(185); chk("f4_s5_c0",   6'h3F, 7'h40, 1'b1);
        to_edge(187); chk("f4_s5_lz",   6'h3F, 7'h40, 1'b1);
        to_edge(188);
        blank_lz = 1'b0;
        to_edge(189); chk("f4_s5_nolz", 6'h1F, 7'h40, 1'b1);

        // Frame 5: pause mid-slot 0 at cnt=4 for 20 cycles
        to_edge(196);
        en = 1'b0;
        to_edge(197); chk("pause_1",  6'h3F, 7'h7F, 1'b1);
        to_edge(210); chk("pause_14", 6'h3F, 7'h7F, 1'b1);
        to_edge(216);
        en = 1'b1;
        to_edge(217); chk("resume_c4",  6'h3E, 7'h19, 1'b1);
        to_edge(220); chk("resume_c7",  6'h3E, 7'h19, 1'b1);
        to_edge(221); chk("resume_s1",  6'h3F, 7'h02, 1'b1);
        to_edge(223); chk("resume_s1a", 6'h3D, 7'h02, 1'b1);

        // Asynchronous reset mid-slot, checked before the next clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 6'h3F, 7'h7F, 1'b1);
        @(negedge clk);
        rst_n  = 1'b1;
        ecount = 0;
        to_edge(1); chk("rst2_blank",  6'h3F, 7'h40, 1'b1);
        to_edge(3); chk("rst2_active", 6'h3E, 7'h40, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
